// File: rtl/pattern_serializer.sv
// pattern_serializer
//   Writable table of DEPTH patterns, WIDTH bits each. A START request in idle
//   selects one entry and shifts it out one bit per clock on o_serial, either
//   LSB- or MSB-first, as a single frame or repeating until STOP.
//
// Ports
//   i_clk        clock, all state on the rising edge
//   i_clear      asynchronous active-high reset (also restores the table)
//   i_wr_en      table write strobe, honoured in every state
//   i_wr_addr    entry written; addresses >= DEPTH are ignored
//   i_wr_data    pattern data written
//   i_start      frame request, sampled in idle only
//   i_sel        entry to serialize, sampled with i_start
//   i_msb_first  1: bit WIDTH-1 first, 0: bit 0 first (sampled with i_start)
//   i_repeat     1: loop frames until stop (sampled with i_start)
//   i_stop       end a repeating run after the current frame
//   o_serial     serial data
//   o_busy       high while shifting
//   o_done       one-cycle frame-complete pulse
//   o_bit_idx    index of the bit currently on o_serial
module pattern_serializer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = $clog2(DEPTH),
  parameter int unsigned CW    = $clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_clear,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_start,
  input  logic [AW-1:0]    i_sel,
  input  logic             i_msb_first,
  input  logic             i_repeat,
  input  logic             i_stop,
  output logic             o_serial,
  output logic             o_busy,
  output logic             o_done,
  output logic [CW-1:0]    o_bit_idx
);

  localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  // Thermometer code with min(idx+1, WIDTH) ones in the LSBs.
  function automatic logic [WIDTH-1:0] thermo(input int unsigned idx);
    logic [WIDTH-1:0] v;
    v = '0;
    for (int unsigned b = 0; b < WIDTH; b++) begin
      if (b <= idx) v[b] = 1'b1;
    end
    return v;
  endfunction

  logic [WIDTH-1:0] r_table [DEPTH];

  state_e           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_shreg;
  logic [AW-1:0]    r_sel;
  logic             r_msb;
  logic             r_rep;
  logic             r_stop_pend;
  logic             r_done;

  logic             w_wr_ok;
  logic [WIDTH-1:0] w_sel_data;
  logic [WIDTH-1:0] w_rld_data;

  assign w_wr_ok = i_wr_en && (32'(i_wr_addr) < DEPTH);

  // Out-of-range selects read as all zeros.
  always_comb begin
    w_sel_data = '0;
    w_rld_data = '0;
    if (32'(i_sel) < DEPTH) w_sel_data = r_table[i_sel];
    if (32'(r_sel) < DEPTH) w_rld_data = r_table[r_sel];
  end

  // Pattern table. Reads above see the pre-write contents at the same edge,
  // so a frame started or reloaded alongside a write gets the old data.
  always_ff @(posedge i_clk or posedge i_clear) begin
    if (i_clear) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_table[i] <= thermo(i);
      end
    end else if (w_wr_ok) begin
      r_table[i_wr_addr] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_clear) begin
    if (i_clear) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_shreg     <= '0;
      r_sel       <= '0;
      r_msb       <= 1'b0;
      r_rep       <= 1'b0;
      r_stop_pend <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_sel   <= i_sel;
            r_msb   <= i_msb_first;
            r_rep   <= i_repeat;
            r_shreg <= w_sel_data;
            r_cnt   <= '0;
            r_state <= StShift;
          end
        end
        StShift: begin
          if (i_stop) r_stop_pend <= 1'b1;
          if (r_cnt == LastCnt) begin
            r_done <= 1'b1;
            // A stop arriving on the last-bit edge still ends the run here.
            if (r_rep && !r_stop_pend && !i_stop) begin
              r_cnt   <= '0;
              r_shreg <= w_rld_data;
            end else begin
              // Clearing shreg/msb makes the idle outputs decode to zero.
              r_state     <= StIdle;
              r_cnt       <= '0;
              r_shreg     <= '0;
              r_msb       <= 1'b0;
              r_rep       <= 1'b0;
              r_stop_pend <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_bit_idx = r_msb ? (LastCnt - r_cnt) : r_cnt;
  assign o_serial  = r_shreg[o_bit_idx];
  assign o_busy    = (r_state == StShift);
  assign o_done    = r_done;

endmodule

// File: doc/pattern_serializer.md
# pattern_serializer

Parametrised, writable pattern-table serializer. Holds DEPTH patterns of WIDTH bits. On a START handshake it shifts the selected pattern out one bit per clock on O, LSB- or MSB-first, as a single frame or repeating. It replaces the fixed 8×8 ROM / 3-bit counter / decoder / 8:1 mux pattern path, and adds loadable entries, frame control and status outputs.

## Interface
- WIDTH, default 8: bits per pattern; must be ≥ 2.
- DEPTH, default 8: number of pattern entries; must be ≥ 2.
- AW, default $clog2(DEPTH): pattern address width.
- CW, default $clog2(WIDTH): bit-index width.
- CLK  input  1  single clock, all state on posedge.
- CLEAR  input  1  reset, asynchronous, active-high.
- WR_EN  input  1  write strobe for the pattern table.
- WR_ADDR  input  AW  table entry written when WR_EN=1.
- WR_DATA  input  WIDTH  pattern data written when WR_EN=1.
- START  input  1  frame request, sampled in IDLE only.
- SEL  input  AW  entry to serialize, sampled with START.
- MSB_FIRST  input  1  1: bit WIDTH-1 first; 0: bit 0 first; sampled with START.
- REPEAT  input  1  1: loop frames until STOP; sampled with START.
- STOP  input  1  end repeat after the current frame.
- O  output  1  serial data.
- BUSY  output  1  high in SHIFT.
- DONE  output  1  one-cycle frame-complete pulse.
- BIT_IDX  output  CW  index of the bit currently on O.

## Operation
- Table reset contents: entry i = thermometer with min(i+1, WIDTH) LSB ones. With WIDTH=8 this gives 0x01, 0x03, 0x07, … 0xFF.
- Table writes:
  - Synchronous; WR_EN is honoured in every state.
  - WR_ADDR ≥ DEPTH is ignored.
- Two states, IDLE and SHIFT.
- IDLE:
  - O=0, BUSY=0, BIT_IDX=0.
  - START=1 at an edge: latch SEL, MSB_FIRST and REPEAT; load the shift register from table[SEL]; go to SHIFT with cnt=0.
  - SEL ≥ DEPTH loads all zeros.
- SHIFT:
  - O = shreg[BIT_IDX].
  - BIT_IDX = cnt when LSB-first, WIDTH-1-cnt when MSB-first.
  - Each edge increments cnt.
- At cnt = WIDTH-1 (last bit):
  - If latched REPEAT=1 and no stop is pending: cnt ← 0, reload shreg from table[latched SEL], stay in SHIFT.
  - Otherwise: go to IDLE.
  - In both cases DONE=1 for the following cycle.
- STOP:
  - Sampled only in SHIFT; sets stop_pending.
  - The current frame always completes; stop_pending clears on the return to IDLE.
  - STOP in a non-repeat frame has no effect.
- START while in SHIFT is ignored, including on the last-bit edge. A new frame needs START sampled in IDLE.
- A write to the entry currently shifting does not change the frame in flight. In repeat mode it takes effect from the next frame.
- Write and START at the same edge to the same entry: the frame loads the old data (read-before-write).

## Timing
- Reset (CLEAR=1, asynchronous):
  - State=IDLE, cnt=0, shreg=0, stop_pending=0.
  - O=0, BUSY=0, DONE=0, BIT_IDX=0.
  - Table restored to reset contents.
  - Takes effect immediately, mid-frame included.
- First posedge with CLEAR=0 is a normal edge.
- START sampled at edge k:
  - BUSY=1 and bit 0 of the frame on O during cycle k+1.
  - Frame bit j on O during cycle k+1+j.
  - Last bit in cycle k+WIDTH.
- Single frame: DONE=1 and BUSY=0 in cycle k+WIDTH+1. START may be sampled at the end of that cycle, so the minimum frame-to-frame gap is one idle cycle.
- Repeat: frames are back-to-back with no gap. DONE=1 coincides with bit 0 of the next frame.
- STOP during frame n: frame n completes; DONE and BUSY=0 in the cycle after its last bit.
- All outputs are glitch-free registered or register-decoded. O depends only on shreg and cnt.

## Test plan
- Reset defaults, WIDTH=8: CLEAR pulse, then START with SEL=2, MSB_FIRST=0 → O=1,1,1,0,0,0,0,0 in cycles k+1..k+8; BUSY high exactly those cycles; DONE=1 only in k+9.
- Write plus MSB-first: write 0xA5 to entry 7, START SEL=7, MSB_FIRST=1 → O=1,0,1,0,0,1,0,1; BIT_IDX=7 down to 0.
- Repeat with stop: START SEL=0, REPEAT=1 → O=1,0,0,0,0,0,0,0 repeating with no gap; DONE every 8 cycles. STOP pulsed at bit 3 of frame 3 → frame 3 completes, then BUSY=0.
- Write during repeat: write 0xF0 to entry 0 during bit 2 of frame 1 → frame 1 stays 0x01; frame 2 shows 0,0,0,0,1,1,1,1 (LSB-first).
- Mid-frame reset: CLEAR at bit 4 after entry 5 was written with 0x00 → O, BUSY, DONE drop to 0 immediately; a subsequent SEL=5 frame outputs 0x3F.
- Ignored and simultaneous requests:
  - START held high during SHIFT → no restart.
  - START and STOP together in IDLE with REPEAT=1 → repeat runs; STOP ignored.
  - SEL beyond DEPTH (DEPTH=6, SEL=7) → 8 zero bits, DONE pulse.
